// File: rtl/iiitb_bcdc_ctrl_if.sv
// rtl/iiitb_bcdc_ctrl_if.sv - command/status bundle between host, BCD counter controller and counter
//
// master: host/top side, drives commands and feeds back the counter value Q
// slave : the controller, drives EN/CLRN to the counter and the status flags
//   START/STOP/CLEAR : single-cycle command pulses
//   MODE, TARGET     : 0 = one-shot / 1 = free-run, packed BCD target
//   Q                : counter value {tens, units}
//   IRQ_ACK          : clears the sticky IRQ
//   EN, CLRN         : count enable and active-low clear to the counter
//   BUSY, DONE, ERR  : running, match pulse, sticky invalid-target flag
//   STATE, IRQ       : state code, sticky interrupt
interface iiitb_bcdc_ctrl_if;
    logic       START;
    logic       STOP;
    logic       CLEAR;
    logic       MODE;
    logic [7:0] TARGET;
    logic [7:0] Q;
    logic       IRQ_ACK;
    logic       EN;
    logic       CLRN;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [1:0] STATE;
    logic       IRQ;

    modport master (
        output START, STOP, CLEAR, MODE, TARGET, Q, IRQ_ACK,
        input  EN, CLRN, BUSY, DONE, ERR, STATE, IRQ
    );

    modport slave (
        input  START, STOP, CLEAR, MODE, TARGET, Q, IRQ_ACK,
        output EN, CLRN, BUSY, DONE, ERR, STATE, IRQ
    );
endinterface

// File: rtl/iiitb_bcdc_ctrl.sv
// rtl/iiitb_bcdc_ctrl.sv - sequencing controller for the two-digit BCD counter
//
// Ports:
//   CK  : clock, rising edge
//   RN  : asynchronous active-low reset
//   bus : iiitb_bcdc_ctrl_if.slave (commands and Q in; EN/CLRN/status out)
// Parameter DIV (>= 2): one count enable every DIV clocks while running.
// Optional feature macro BCDC_CTRL_IRQ_EN: sticky IRQ set by DONE, cleared by
// IRQ_ACK; when undefined IRQ is tied low and IRQ_ACK is ignored.
module iiitb_bcdc_ctrl #(
    parameter int DIV = 4
) (
    input  logic             CK,
    input  logic             RN,
    iiitb_bcdc_ctrl_if.slave bus
);
    localparam int PW = $clog2(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("iiitb_bcdc_ctrl: DIV must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] p, p_d;
    logic          armed, armed_d;
    logic          en, en_d;
    logic          clrn, clrn_d;
    logic          done, done_d;
    logic          err, err_d;
    logic [7:0]    target_l, target_d;
    logic          mode_l, mode_d;
    logic          irq;

    // CLEAR > STOP > START: a higher-priority pulse masks the lower ones.
    logic cmd_stop, cmd_start, tgt_ok, p_wrap, match;
    assign cmd_stop  = bus.STOP & ~bus.CLEAR;
    assign cmd_start = bus.START & ~bus.STOP & ~bus.CLEAR;
    assign tgt_ok    = (bus.TARGET[7:4] <= 4'd9) && (bus.TARGET[3:0] <= 4'd9);
    assign p_wrap    = (p == PW'(DIV - 1));
    // Arm-gated so a start with Q already at the target does not fire at once;
    // !en skips the cycle in which the counter is about to change.
    assign match     = armed && !en && (bus.Q == target_l);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state    <= S_IDLE;
            p        <= '0;
            armed    <= 1'b0;
            en       <= 1'b0;
            clrn     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            target_l <= 8'h00;
            mode_l   <= 1'b0;
        end else begin
            state    <= state_d;
            p        <= p_d;
            armed    <= armed_d;
            en       <= en_d;
            clrn     <= clrn_d;
            done     <= done_d;
            err      <= err_d;
            target_l <= target_d;
            mode_l   <= mode_d;
        end
    end

    always_comb begin
        state_d = state;
        if (bus.CLEAR) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cmd_start && tgt_ok) state_d = S_RUN;
                S_RUN: begin
                    if (cmd_stop)               state_d = S_PAUSE;
                    else if (match && !mode_l)  state_d = S_DONE;
                end
                S_PAUSE: if (cmd_start) state_d = S_RUN;
                S_DONE:  if (cmd_start && tgt_ok) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        p_d      = p;
        armed_d  = armed | en;   // the counter steps on every edge with EN high
        en_d     = 1'b0;
        clrn_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = err;
        target_d = target_l;
        mode_d   = mode_l;
        if (bus.CLEAR) begin
            p_d     = '0;
            armed_d = 1'b0;
            err_d   = 1'b0;
            clrn_d  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        if (!tgt_ok) begin
                            err_d = 1'b1;
                        end else begin
                            target_d = bus.TARGET;
                            mode_d   = bus.MODE;
                            p_d      = '0;
                            armed_d  = 1'b0;
                            if (state == S_IDLE) err_d = 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // STOP holds p where it is so a resume keeps the phase.
                    if (!cmd_stop) begin
                        if (p_wrap) begin
                            p_d  = '0;
                            en_d = 1'b1;
                        end else begin
                            p_d = p + 1'b1;
                        end
                        if (match) begin
                            done_d = 1'b1;
                            if (mode_l) armed_d = 1'b0;
                            else        en_d    = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCDC_CTRL_IRQ_EN
    always_ff @(posedge CK or negedge RN) begin
        if (!RN)              irq <= 1'b0;
        else if (done)        irq <= 1'b1;
        else if (bus.IRQ_ACK) irq <= 1'b0;
    end
`else
    logic unused_irq_ack;
    assign unused_irq_ack = bus.IRQ_ACK;
    assign irq = 1'b0;
`endif

    assign bus.EN    = en;
    assign bus.CLRN  = clrn;
    assign bus.BUSY  = (state == S_RUN);
    assign bus.DONE  = done;
    assign bus.ERR   = err;
    assign bus.STATE = state;
    assign bus.IRQ   = irq;
endmodule

// File: doc/iiitb_bcdc_ctrl.md
# iiitb_bcdc_ctrl

Sequencing controller for the two-digit BCD counter. It generates the counter's count-enable from a programmable prescaler, handles start/stop/clear commands, and watches the counter's packed `Q` output against a BCD target. In one-shot mode it halts the count at the target; in free-run mode it flags each pass of the target. It sits between the management/IO command inputs and the counter instance in the user project.

## Interface
- `DIV`, default 4: prescaler divide ratio, one count enable per `DIV` clocks; legal range ≥2, elaboration error otherwise. Prescaler width is ceil(log2(DIV)).
- `CK` input 1: single clock, rising edge.
- `RN` input 1: asynchronous, active-low reset.
- `START` input 1: single-cycle command pulse, synchronous to `CK`.
- `STOP` input 1: single-cycle command pulse, synchronous to `CK`.
- `CLEAR` input 1: single-cycle command pulse, synchronous to `CK`.
- `MODE` input 1: 0 = one-shot, 1 = free-run; latched on accepted `START`.
- `TARGET` input 8: packed BCD {tens, units}; latched on accepted `START`.
- `Q` input 8: counter value {tens, units}, fed back from the counter.
- `EN` output 1: registered count enable to the counter.
- `CLRN` output 1: registered active-low counter clear; the top level ANDs it into the counter reset.
- `BUSY` output 1: high while in RUN.
- `DONE` output 1: one-cycle registered match pulse.
- `ERR` output 1: sticky flag for an invalid target.
- `STATE` output 2: current state code.
- `IRQ` output 1: sticky interrupt (see Configuration).
- `IRQ_ACK` input 1: clears `IRQ`.

## Operation
- States:
  - IDLE = 00
  - RUN = 01
  - PAUSE = 10
  - DONE = 11
- Command priority when pulses coincide: CLEAR > STOP > START.
- CLEAR, in any state:
  - next state IDLE.
  - prescaler 0, `armed` 0, `ERR` 0, `EN` 0.
  - `CLRN` low for exactly one cycle.
- IDLE + START:
  - If either `TARGET` nibble is >9: stay IDLE and set `ERR`.
  - Otherwise: latch `TARGET`/`MODE`, clear `ERR`, prescaler 0, `armed` 0, go to RUN.
- RUN:
  - Prescaler `p`: if `p==DIV-1`, then `p<=0` and `EN<=1`; else `p<=p+1` and `EN<=0`.
  - On any edge where `EN==1`, set `armed<=1`. The counter increments on that edge.
  - Match condition: `armed && !EN && Q==target_l`.
  - One-shot match: next state DONE, `EN<=0` (match overrides the prescaler), `DONE` pulse.
  - Free-run match: stay RUN, `DONE` pulse, `armed<=0`, prescaler unaffected.
  - STOP: go to PAUSE with `p` held and `EN<=0`.
  - START while in RUN: ignored.
- PAUSE:
  - START resumes RUN from the held `p`; target is not relatched.
  - STOP is ignored.
- DONE:
  - START with a valid target: relatch target/mode, `p<=0`, `armed<=0`, go to RUN. The counter is not cleared and continues from `Q`.
  - START with an invalid target: set `ERR`, stay DONE.
- `EN` is only ever high in RUN.
- `BUSY = (STATE==RUN)`.
- Matching is arm-gated, so a start with `Q==target` in one-shot mode counts the full 100 ticks (wraps through 99→00) before matching.

## Timing
- Reset values:
  - `EN`=0, `CLRN`=1, `BUSY`=0, `DONE`=0, `ERR`=0, `STATE`=00, `IRQ`=0.
  - Internal: `p`=0, `armed`=0, `target_l`=00, `mode_l`=0.
- START accepted at edge s:
  - First `EN` high in the cycle after edge s+DIV.
  - The Nth `EN` is set at edge s+N·DIV; the counter shows the new value after edge s+N·DIV+1.
  - One-shot `DONE` is high in the cycle after edge s+N·DIV+2, where N = ticks to the target.
- `DONE` is one cycle wide; `STATE` updates on the same edge.
- RN asserted mid-RUN: all outputs return to reset values immediately (asynchronously), not on the next edge.

## Configuration
- `BCDC_CTRL_IRQ_EN`:
  - Defined: `IRQ` sets on any `DONE` pulse and holds until an `IRQ_ACK` cycle. Set has priority over ack in the same cycle.
  - Undefined: `IRQ` is tied to 0 and `IRQ_ACK` is ignored.

## Test plan
- DIV=4, `Q`=00, START with TARGET=0x05, MODE=0 → five `EN` pulses spaced 4 cycles apart; `DONE` 22 cycles after START; `STATE`=11; `Q` holds 05.
- DIV=4, free-run, TARGET=0x02 → `DONE` pulses each time `Q` reaches 02 (every 100 ticks after the first); `STATE` stays 01.
- START with TARGET=0x1A → `ERR`=1, `STATE`=00, no `EN`; then CLEAR → `ERR`=0.
- RUN, then STOP mid-prescale with `p`=2, then START → next `EN` exactly 2 cycles after resume (DIV=4); STOP and START in the same cycle → PAUSE.
- One-shot, `Q`=37, TARGET=0x37 → no immediate `DONE`; `DONE` after 100 ticks. CLEAR mid-RUN → `CLRN` low for one cycle and `STATE`=00.
- With `BCDC_CTRL_IRQ_EN` defined: `DONE` → `IRQ`=1, held until `IRQ_ACK`. RN pulsed low mid-RUN → all outputs at reset values immediately.
